// File: rtl/gauss_conv_mac_pkg.sv
// conv_pkg: FSM states, Q0.8 constants and accumulator sizing shared by gauss_conv_mac.
package conv_pkg;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    localparam int FRAC_W = 8;
    localparam int ROUND_C = 128;
    function automatic int acc_width(input int pix_w, input int max_k);
        return pix_w + FRAC_W + $clog2(max_k * max_k);
    endfunction
endpackage

// File: rtl/gauss_conv_mac_if.sv
// gauss_conv_mac_if: kernel load, window and result handshakes plus status flags.
interface gauss_conv_mac_if
    import conv_pkg::*;
#(
    parameter int MAX_KERNEL = 3,
    parameter int PIX_W = 8
);
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][FRAC_W-1:0] kernel;
    logic kernel_valid;
    logic [$clog2(MAX_KERNEL):0] kernel_size;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] window;
    logic win_valid, win_ready;
    logic [PIX_W-1:0] pix_out;
    logic out_valid, out_ready, busy, err;
    modport master(
        output kernel, kernel_valid, kernel_size, window, win_valid, out_ready,
        input win_ready, pix_out, out_valid, busy, err
    );
    modport slave(
        input kernel, kernel_valid, kernel_size, window, win_valid, out_ready,
        output win_ready, pix_out, out_valid, busy, err
    );
endinterface

// File: rtl/gauss_conv_mac_flex_counter.sv
// flex_counter: wrapping up-counter whose terminal value is supplied at run time.
module flex_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         rollover
);
    assign rollover = en && count == last;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= rollover ? '0 : count + 1'b1;
endmodule

// File: rtl/gauss_conv_mac.sv
// gauss_conv_mac: Q0.8 Gaussian convolution, one kernel tap multiplied and accumulated per cycle.
// Define GAUSS_CONV_ROUND_EN to round the result to nearest; otherwise it truncates.
module gauss_conv_mac
    import conv_pkg::*;
#(
    parameter int MAX_KERNEL = 3,
    parameter int PIX_W = 8
) (
    input logic clk,
    input logic rst,
    gauss_conv_mac_if.slave bus
);
    localparam int KS_W = $clog2(MAX_KERNEL) + 1;
    localparam int IDX_W = MAX_KERNEL > 1 ? $clog2(MAX_KERNEL) : 1;
    localparam int ACC_W = acc_width(PIX_W, MAX_KERNEL);
    typedef logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][FRAC_W-1:0] kern_t;

    state_t state;
    kern_t coef, pend_k, ld_k;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] win_r;
    logic [KS_W-1:0] ks, pend_s, ld_s;
    logic loaded, pend_v, ld_en, accept, done, x_roll, last_tap;
    logic [IDX_W-1:0] x, y, ks_last;
    logic [ACC_W-1:0] acc, acc_next;
    logic [ACC_W:0] sum, shf;
    logic [PIX_W+FRAC_W-1:0] prod;
    logic [PIX_W-1:0] res;

    function automatic logic legal(input logic [KS_W-1:0] s);
        return s != '0 && s <= KS_W'(MAX_KERNEL);
    endfunction

    assign accept = bus.win_valid && bus.win_ready;
    assign done = state == OUT && bus.out_ready;
    assign bus.win_ready = state == IDLE && loaded && legal(ks);
    assign bus.busy = state != IDLE;
    assign ks_last = IDX_W'(ks - 1'b1);

    flex_counter #(.W(IDX_W)) u_x (
        .clk(clk), .rst(rst), .clr(accept), .en(state == MAC),
        .last(ks_last), .count(x), .rollover(x_roll)
    );
    flex_counter #(.W(IDX_W)) u_y (
        .clk(clk), .rst(rst), .clr(accept), .en(x_roll),
        .last(ks_last), .count(y), .rollover(last_tap)
    );

    assign prod = {{FRAC_W{1'b0}}, win_r[y][x]} * {{PIX_W{1'b0}}, coef[y][x]};
    assign acc_next = acc + ACC_W'(prod);
`ifdef GAUSS_CONV_ROUND_EN
    assign sum = {1'b0, acc_next} + (ACC_W+1)'(ROUND_C);
`else
    assign sum = {1'b0, acc_next};
`endif
    assign shf = sum >> FRAC_W;
    assign res = |shf[ACC_W:PIX_W] ? '1 : shf[PIX_W-1:0];

    // A kernel arriving while a window is in flight waits in the shadow until the result is taken.
    assign ld_en = (state == IDLE && bus.kernel_valid) || (done && (bus.kernel_valid || pend_v));
    assign ld_k = bus.kernel_valid ? bus.kernel : pend_k;
    assign ld_s = bus.kernel_valid ? bus.kernel_size : pend_s;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            bus.pix_out <= '0;
            bus.out_valid <= 1'b0;
            bus.err <= 1'b0;
            loaded <= 1'b0;
            acc <= '0;
            pend_v <= 1'b0;
            pend_k <= '0;
            pend_s <= '0;
            coef <= '0;
            ks <= '0;
            win_r <= '0;
        end else begin
            if (ld_en) begin
                coef <= ld_k;
                ks <= ld_s;
                loaded <= 1'b1;
                bus.err <= !legal(ld_s);
            end
            if (bus.kernel_valid && state != IDLE && !done) begin
                pend_k <= bus.kernel;
                pend_s <= bus.kernel_size;
                pend_v <= 1'b1;
            end else if (done) pend_v <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    win_r <= bus.window;
                    acc <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc_next;
                    if (last_tap) begin
                        bus.pix_out <= res;
                        bus.out_valid <= 1'b1;
                        state <= OUT;
                    end
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_gauss_conv_mac.sv
// tb_gauss_conv_mac: directed and randomized checks of gauss_conv_mac against a behavioural model.
module tb_gauss_conv_mac;
    import conv_pkg::*;
    localparam int MK = 3, PW = 8, KW = $clog2(MK) + 1;
`ifdef GAUSS_CONV_ROUND_EN
    localparam int EXP200 = 197, EXP28 = 28;
`else
    localparam int EXP200 = 196, EXP28 = 27;
`endif
    typedef logic [MK-1:0][MK-1:0][7:0] kern_t;
    typedef logic [MK-1:0][MK-1:0][PW-1:0] win_t;

    logic clk = 0, rst = 1;
    int checks = 0, failures = 0, cyc = 0;
    always #5 clk = ~clk;

    gauss_conv_mac_if #(.MAX_KERNEL(MK), .PIX_W(PW)) bus();
    gauss_conv_mac #(.MAX_KERNEL(MK), .PIX_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic kern_t fill_k(int v);
        kern_t k;
        for (int y = 0; y < MK; y++) for (int x = 0; x < MK; x++) k[y][x] = 8'(v);
        return k;
    endfunction
    function automatic win_t fill_w(int v);
        win_t w;
        for (int y = 0; y < MK; y++) for (int x = 0; x < MK; x++) w[y][x] = PW'(v);
        return w;
    endfunction
    function automatic bit legal(int n);
        return n >= 1 && n <= MK;
    endfunction
    function automatic int raw_sum(kern_t k, int n, win_t w);
        int s = 0;
        for (int y = 0; y < n; y++) for (int x = 0; x < n; x++) s += int'(w[y][x]) * int'(k[y][x]);
        return s;
    endfunction
    function automatic int ref_pix(kern_t k, int n, win_t w);
        int s = raw_sum(k, n, w);
`ifdef GAUSS_CONV_ROUND_EN
        s = (s + 128) / 256;
`else
        s = s / 256;
`endif
        return s > (1 << PW) - 1 ? (1 << PW) - 1 : s;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: active kernel, shadow kernel and the single in-flight window with its due cycle.
    kern_t mk, pk;
    int ms = 0, ps = 0, exp_at = 0, exp_pix = 0;
    bit mloaded = 0, pv = 0, inflight = 0, rdy;
    always @(posedge clk) begin
        if (rst) begin
            inflight = 0; mloaded = 0; pv = 0; ms = 0;
        end else begin
            rdy = !inflight && mloaded && legal(ms);
            if (inflight && cyc >= exp_at && bus.out_ready) begin
                inflight = 0;
                if (bus.kernel_valid) begin mk = bus.kernel; ms = int'(bus.kernel_size); mloaded = 1; end
                else if (pv) begin mk = pk; ms = ps; mloaded = 1; end
                pv = 0;
            end else if (bus.kernel_valid) begin
                if (inflight) begin pk = bus.kernel; ps = int'(bus.kernel_size); pv = 1; end
                else begin mk = bus.kernel; ms = int'(bus.kernel_size); mloaded = 1; end
            end
            if (rdy && bus.win_valid) begin
                inflight = 1;
                exp_pix = ref_pix(mk, ms, bus.window);
                exp_at = cyc + ms * ms + 1;
            end
        end
        cyc++;
    end

    always @(negedge clk) if (!rst) begin
        chk("win_ready", int'(bus.win_ready), int'(!inflight && mloaded && legal(ms)));
        chk("busy", int'(bus.busy), int'(inflight));
        chk("err", int'(bus.err), int'(mloaded && !legal(ms)));
        chk("out_valid", int'(bus.out_valid), int'(inflight && cyc >= exp_at));
        if (inflight && cyc >= exp_at) chk("pix_out", int'(bus.pix_out), exp_pix);
    end

    task automatic step(int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask
    task automatic load_kernel(kern_t k, int n);
        bus.kernel = k; bus.kernel_size = KW'(n); bus.kernel_valid = 1;
        step();
        bus.kernel_valid = 0;
    endtask
    task automatic wait_out(output bit ok);
        int k = 0;
        while (!bus.out_valid && k < 50) begin step(); k++; end
        ok = bus.out_valid;
        if (!ok) chk("out_valid_timeout", 0, 1);
    endtask
    task automatic send_window(win_t w, int stall, output int res, output int lat);
        int t, k = 0;
        bit ok;
        res = -1; lat = -1;
        bus.window = w; bus.win_valid = 1;
        while (!bus.win_ready && k < 50) begin step(); k++; end
        if (!bus.win_ready) begin chk("win_accept_timeout", 0, 1); bus.win_valid = 0; return; end
        t = cyc;
        step();
        bus.win_valid = 0;
        wait_out(ok);
        if (!ok) return;
        lat = cyc - t; res = int'(bus.pix_out);
        step(stall);
        bus.out_ready = 1; step(); bus.out_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int r, l;
        bit ok;
        kern_t k;
        win_t w;
        bus.kernel = '0; bus.kernel_valid = 0; bus.kernel_size = '0;
        bus.window = '0; bus.win_valid = 0; bus.out_ready = 0;
        step(3);
        chk("rst_pix_out", int'(bus.pix_out), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_win_ready", int'(bus.win_ready), 0);
        rst = 0;
        step();
        chk("model_round", ref_pix(fill_k(28), 3, fill_w(200)), EXP200);
        chk("model_acc_max", raw_sum(fill_k(255), 3, fill_w(255)), 585225);

        load_kernel(fill_k(28), 3);
        send_window(fill_w(200), 0, r, l);
        chk("req032_pix", r, EXP200);
        chk("req032_latency", l, 10);

        load_kernel(fill_k(255), 3);
        send_window(fill_w(255), 0, r, l);
        chk("req033_saturate", r, 255);

        load_kernel(fill_k(28), 3);
        bus.window = fill_w(200); bus.win_valid = 1;
        step();
        bus.win_valid = 0;
        wait_out(ok);
        repeat (5) begin
            chk("req034_stall_pix", int'(bus.pix_out), EXP200);
            chk("req034_stall_win_ready", int'(bus.win_ready), 0);
            step();
        end
        bus.out_ready = 1; step(); bus.out_ready = 0;
        chk("req034_idle_busy", int'(bus.busy), 0);
        chk("req034_idle_out_valid", int'(bus.out_valid), 0);

        bus.window = fill_w(28); bus.win_valid = 1;
        step();
        bus.win_valid = 0;
        step(4);
        rst = 1;
        #1;
        chk("req036_pix_out", int'(bus.pix_out), 0);
        chk("req036_out_valid", int'(bus.out_valid), 0);
        chk("req036_busy", int'(bus.busy), 0);
        step();
        rst = 0;
        step(20);
        chk("req036_win_ready", int'(bus.win_ready), 0);

        load_kernel(fill_k(28), 3);
        fork
            send_window(fill_w(28), 0, r, l);
            begin step(3); load_kernel(fill_k(0), 3); end
        join
        chk("req035_old_coef", r, EXP28);
        send_window(fill_w(28), 0, r, l);
        chk("req035_new_coef", r, 0);

        load_kernel(fill_k(28), 4);
        chk("req037_err_set", int'(bus.err), 1);
        chk("req037_win_ready", int'(bus.win_ready), 0);
        load_kernel(fill_k(28), 3);
        chk("req037_err_clr", int'(bus.err), 0);
        chk("req037_win_ready_back", int'(bus.win_ready), 1);

        for (int i = 0; i < 60; i++) begin
            for (int y = 0; y < MK; y++) for (int x = 0; x < MK; x++) begin
                k[y][x] = 8'($urandom_range(0, 255) >> $urandom_range(0, 3));
                w[y][x] = PW'($urandom);
            end
            if (i % 4 == 0) load_kernel(k, $urandom_range(1, MK));
            if ($urandom_range(0, 3) == 0)
                fork
                    send_window(w, $urandom_range(0, 3), r, l);
                    begin step($urandom_range(1, 4)); load_kernel(~k, $urandom_range(1, MK)); end
                join
            else send_window(w, $urandom_range(0, 3), r, l);
        end

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
